// File: rtl/mult_pkg.sv
// Shared types and sizing for the parity-checked signed multiplier.
// MULT_ITERATIVE_EN selects the shift-add datapath in mult_core.
package mult_pkg;
  localparam int DATA_W   = 16;
  localparam int RESULT_W = 2 * DATA_W;

  typedef enum logic [1:0] {IDLE, CHECK, CALC, DONE} mult_state_t;

  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] x);
    return x[DATA_W-1] ? -x : x;
  endfunction
endpackage

// File: rtl/mult_core_if.sv
// Operand request / product response bundle between the stimulus stage and mult_core.
interface mult_core_if;
  import mult_pkg::*;

  logic                req;
  logic [DATA_W-1:0]   arg_a;
  logic                arg_a_parity;
  logic [DATA_W-1:0]   arg_b;
  logic                arg_b_parity;
  logic                ack;
  logic                result_rdy;
  logic [RESULT_W-1:0] result;
  logic                result_parity;
  logic                arg_parity_error;

  modport master (
    output req, arg_a, arg_a_parity, arg_b, arg_b_parity,
    input  ack, result_rdy, result, result_parity, arg_parity_error
  );

  modport slave (
    input  req, arg_a, arg_a_parity, arg_b, arg_b_parity,
    output ack, result_rdy, result, result_parity, arg_parity_error
  );
endinterface

// File: rtl/mult_shift_add.sv
// Radix-2 shift-add multiplier: one partial product per cycle over DATA_W cycles,
// operating on magnitudes with the sign applied to the final sum.
module mult_shift_add
  import mult_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  output logic                     done_o,
  output logic [RESULT_W-1:0]      product_o
);
  localparam int CNT_W = $clog2(DATA_W);

  logic [RESULT_W-1:0] mcand_q, acc_q, acc_nxt;
  logic [DATA_W-1:0]   mplier_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                busy_q, neg_q;

  assign acc_nxt   = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done_o    = busy_q && (cnt_q == CNT_W'(DATA_W - 1));
  // product_o is only meaningful alongside done_o: it includes the final step.
  assign product_o = neg_q ? -acc_nxt : acc_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      neg_q    <= 1'b0;
    end else if (start_i) begin
      mcand_q  <= RESULT_W'(mag(a_i));
      mplier_q <= mag(b_i);
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
      neg_q    <= a_i[DATA_W-1] ^ b_i[DATA_W-1];
    end else if (busy_q) begin
      acc_q    <= acc_nxt;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
      if (done_o) busy_q <= 1'b0;
    end
  end
endmodule

// File: rtl/mult_core.sv
// Signed DATA_W x DATA_W multiplier with operand parity check and req/ack handshake.
// Define MULT_ITERATIVE_EN for the DATA_W-cycle shift-add CALC instead of a single-cycle multiply.
module mult_core
  import mult_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  mult_core_if.slave  bus
);
  mult_state_t                state_q, state_d;
  logic signed [DATA_W-1:0]   a_q, b_q;
  logic                       ap_q, bp_q;
  logic                       err_q, err_d;
  logic [RESULT_W-1:0]        result_q, result_d;
  logic                       res_par_q;
  logic                       perr, calc_done;
  logic [RESULT_W-1:0]        prod;

  assign perr = (^a_q != ap_q) || (^b_q != bp_q);

`ifdef MULT_ITERATIVE_EN
  logic calc_start;
  assign calc_start = (state_q == CHECK) && !perr;

  mult_shift_add u_shift_add (
    .clk       (clk),
    .rst       (rst),
    .start_i   (calc_start),
    .a_i       (a_q),
    .b_i       (b_q),
    .done_o    (calc_done),
    .product_o (prod)
  );
`else
  logic signed [RESULT_W-1:0] prod_s;
  assign prod_s    = a_q * b_q;
  assign prod      = prod_s;
  assign calc_done = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    result_d = result_q;
    unique case (state_q)
      IDLE:  if (bus.req) state_d = CHECK;
      CHECK: begin
        if (perr) begin
          state_d  = DONE;
          err_d    = 1'b1;
          result_d = '0;
        end else begin
          state_d  = CALC;
          err_d    = 1'b0;
        end
      end
      CALC: begin
        if (calc_done) begin
          state_d  = DONE;
          result_d = prod;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      ap_q      <= 1'b0;
      bp_q      <= 1'b0;
      err_q     <= 1'b0;
      result_q  <= '0;
      res_par_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      result_q  <= result_d;
      res_par_q <= ^result_d;
      // Operands are sampled only when a transaction starts; later bus changes are ignored.
      if (state_q == IDLE && bus.req) begin
        a_q  <= bus.arg_a;
        b_q  <= bus.arg_b;
        ap_q <= bus.arg_a_parity;
        bp_q <= bus.arg_b_parity;
      end
    end
  end

  assign bus.ack              = (state_q == CHECK);
  assign bus.result_rdy       = (state_q == DONE);
  assign bus.arg_parity_error = (state_q == DONE) && err_q;
  assign bus.result           = result_q;
  assign bus.result_parity    = res_par_q;
endmodule

// File: tb/tb_mult_core.sv
// Scoreboard bench for mult_core: stimulus queues expected ack/result events, a negedge monitor checks them.
module tb_mult_core;
  import mult_pkg::*;

`ifdef MULT_ITERATIVE_EN
  localparam int LAT_GOOD = 2 + DATA_W;
`else
  localparam int LAT_GOOD = 3;
`endif

  typedef struct {
    int          cyc;
    logic [31:0] res;
    logic        par;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  int   ack_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mult_core_if bus();

  mult_core dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every ack / result_rdy pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.ack === 1'b1) begin
      if (ack_q.size() == 0) chk("unexpected_ack", 32'd1, 32'd0);
      else chk("ack_cycle", cyc, ack_q.pop_front());
    end
    if (bus.result_rdy === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_result_rdy", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("rdy_cycle", cyc, e.cyc);
        chk("result", bus.result, e.res);
        chk("result_parity", {31'd0, bus.result_parity}, {31'd0, e.par});
        chk("arg_parity_error", {31'd0, bus.arg_parity_error}, {31'd0, e.err});
      end
    end
  end

  task automatic txn(input logic [15:0] a, input logic ap, input logic [15:0] b, input logic bp,
                     input logic [31:0] res, input logic err, input int n);
    int lat;
    int period;
    exp_t e;
    lat    = err ? 2 : LAT_GOOD;
    period = lat + 1;
    @(negedge clk);
    for (int k = 0; k < n; k++) begin
      ack_q.push_back(cyc + 1 + k * period);
      e.cyc = cyc + lat + k * period;
      e.res = res;
      e.par = ^res;
      e.err = err;
      sb.push_back(e);
    end
    bus.req          = 1'b1;
    bus.arg_a        = a;
    bus.arg_a_parity = ap;
    bus.arg_b        = b;
    bus.arg_b_parity = bp;
    repeat ((n - 1) * period + 1) @(negedge clk);
    bus.req   = 1'b0;
    bus.arg_a = 16'h5A5A;
    bus.arg_b = 16'hA5A5;
    repeat (lat + 1) @(negedge clk);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ack"}, {31'd0, bus.ack}, 32'd0);
    chk({tag, "_result_rdy"}, {31'd0, bus.result_rdy}, 32'd0);
    chk({tag, "_result"}, bus.result, 32'd0);
    chk({tag, "_result_parity"}, {31'd0, bus.result_parity}, 32'd0);
    chk({tag, "_arg_parity_error"}, {31'd0, bus.arg_parity_error}, 32'd0);
  endtask

  initial begin
    rst              = 1'b1;
    bus.req          = 1'b0;
    bus.arg_a        = '0;
    bus.arg_a_parity = 1'b0;
    bus.arg_b        = '0;
    bus.arg_b_parity = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    rst = 1'b0;

    txn(16'h0003, 1'b0, 16'hFFFB, 1'b1, 32'hFFFF_FFF1, 1'b0, 1);  // 3 * -5
    txn(16'h8000, 1'b1, 16'h8000, 1'b1, 32'h4000_0000, 1'b0, 1);
    txn(16'h7FFF, 1'b0, 16'h0001, 1'b1, 32'h0000_0000, 1'b1, 1);  // bad a parity
    txn(16'hFFFF, 1'b1, 16'h0001, 1'b0, 32'h0000_0000, 1'b1, 1);  // both bad
    txn(16'h0005, 1'b0, 16'h0003, 1'b1, 32'h0000_0000, 1'b1, 1);  // bad b parity
    txn(16'h7FFF, 1'b1, 16'h7FFF, 1'b1, 32'h3FFF_0001, 1'b0, 1);
    txn(16'h1234, 1'b1, 16'h0000, 1'b0, 32'h0000_0000, 1'b0, 1);
    txn(16'h8000, 1'b1, 16'h7FFF, 1'b1, 32'hC000_8000, 1'b0, 1);

    // Reset while in CALC: ack is seen, the result must never appear.
    @(negedge clk);
    ack_q.push_back(cyc + 1);
    bus.req          = 1'b1;
    bus.arg_a        = 16'h0002;
    bus.arg_a_parity = 1'b1;
    bus.arg_b        = 16'h0002;
    bus.arg_b_parity = 1'b1;
    @(negedge clk);
    bus.req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_idle_outputs("abort");
    rst = 1'b0;
    repeat (LAT_GOOD + 2) @(negedge clk);
    txn(16'h0001, 1'b1, 16'h0001, 1'b1, 32'h0000_0001, 1'b0, 1);

    // req held high: back-to-back transactions, one ack each.
    txn(16'hFFFF, 1'b0, 16'h8000, 1'b1, 32'h0000_8000, 1'b0, 3);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    chk("ack_queue_drained", ack_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
